// File: rtl/decouple_reset_sequencer_pkg.sv
// Shared types and defaults for the application-region decouple/reset sequencer.
package decouple_seq_pkg;

  typedef enum logic [2:0] {
    ST_RUNNING     = 3'd0,
    ST_DRAIN       = 3'd1,
    ST_DEC_SETTLE  = 3'd2,
    ST_RST_HOLD    = 3'd3,
    ST_ISOLATED    = 3'd4,
    ST_RST_RELEASE = 3'd5
  } seq_state_t;

  localparam int unsigned DEF_SETTLE_CYCLES  = 32'd8;
  localparam int unsigned DEF_RESET_CYCLES   = 32'd16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1024;

  function automatic logic state_decoupled(seq_state_t s);
    case (s)
      ST_DEC_SETTLE, ST_RST_HOLD, ST_ISOLATED, ST_RST_RELEASE: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

  function automatic logic state_in_reset(seq_state_t s);
    case (s)
      ST_RST_HOLD, ST_ISOLATED: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic state_busy(seq_state_t s);
    case (s)
      ST_RUNNING, ST_ISOLATED: return 1'b0;
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/decouple_reset_sequencer_if.sv
// Request/status bundle between the control register file, the sequencer and the region controls.
interface decouple_reset_sequencer_if;

  logic       start_isolate;
  logic       start_release;
  logic       app_idle;
  logic       clear_err;
  logic       decouple;
  logic       assert_reset;
  logic       busy;
  logic       isolated;
  logic       timeout_err;
  logic [2:0] state_o;

  modport master (
    output start_isolate, start_release, app_idle, clear_err,
    input  decouple, assert_reset, busy, isolated, timeout_err, state_o
  );

  modport slave (
    input  start_isolate, start_release, app_idle, clear_err,
    output decouple, assert_reset, busy, isolated, timeout_err, state_o
  );

endinterface

// File: rtl/decouple_reset_sequencer.sv
// Isolate/release sequencer: drain -> decouple -> reset on the way out, reset drop -> undecouple on the way back.
module decouple_reset_sequencer
  import decouple_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH      = 32'd16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  decouple_reset_sequencer_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD  = CNT_WIDTH'(SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] RESET_LOAD   = CNT_WIDTH'(RESET_CYCLES - 32'd1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 32'd1);

  seq_state_t           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_decouple;
  logic                 r_assert_reset;
  logic                 r_busy;
  logic                 r_isolated;
  logic                 r_timeout_err;

  seq_state_t           w_next_state;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_dec;
  logic                 w_cnt_zero;
  logic                 w_set_err;

  assign w_cnt_zero = (r_cnt == CNT_ZERO);
  assign w_cnt_dec  = w_cnt_zero ? CNT_ZERO : (r_cnt - CNT_ONE);

  // Next-state and counter decode; requests not legal in the current state fall through untouched.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_set_err    = 1'b0;
    case (r_state)
      ST_RUNNING: begin
        if (bus.start_isolate) begin
          w_next_state = ST_DRAIN;
          w_next_cnt   = TIMEOUT_LOAD;
        end else begin
          w_next_state = ST_RUNNING;
        end
      end
      ST_DRAIN: begin
        // Idle on the final count still counts as a clean drain.
        if (bus.app_idle) begin
          w_next_state = ST_DEC_SETTLE;
          w_next_cnt   = SETTLE_LOAD;
        end else if (w_cnt_zero) begin
          w_next_state = ST_DEC_SETTLE;
          w_next_cnt   = SETTLE_LOAD;
          w_set_err    = 1'b1;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      ST_DEC_SETTLE: begin
        if (w_cnt_zero) begin
          w_next_state = ST_RST_HOLD;
          w_next_cnt   = RESET_LOAD;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      ST_RST_HOLD: begin
        if (w_cnt_zero) begin
          w_next_state = ST_ISOLATED;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      ST_ISOLATED: begin
        if (bus.start_release) begin
          w_next_state = ST_RST_RELEASE;
          w_next_cnt   = SETTLE_LOAD;
        end else begin
          w_next_state = ST_ISOLATED;
        end
      end
      ST_RST_RELEASE: begin
        if (w_cnt_zero) begin
          w_next_state = ST_RUNNING;
        end else begin
          w_next_cnt   = w_cnt_dec;
        end
      end
      default: begin
        w_next_state = ST_RUNNING;
        w_next_cnt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and Moore outputs decoded from the next state so they move with it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= ST_RUNNING;
      r_cnt          <= CNT_ZERO;
      r_decouple     <= 1'b0;
      r_assert_reset <= 1'b0;
      r_busy         <= 1'b0;
      r_isolated     <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_cnt          <= w_next_cnt;
      r_decouple     <= state_decoupled(w_next_state);
      r_assert_reset <= state_in_reset(w_next_state);
      r_busy         <= state_busy(w_next_state);
      r_isolated     <= (w_next_state == ST_ISOLATED);
      if (w_set_err) begin
        r_timeout_err <= 1'b1;
      end else if (bus.clear_err) begin
        r_timeout_err <= 1'b0;
      end else begin
        r_timeout_err <= r_timeout_err;
      end
    end
  end

  assign bus.decouple     = r_decouple;
  assign bus.assert_reset = r_assert_reset;
  assign bus.busy         = r_busy;
  assign bus.isolated     = r_isolated;
  assign bus.timeout_err  = r_timeout_err;
  assign bus.state_o      = r_state;

endmodule

// File: tb/tb_decouple_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output transitions, a negedge monitor matches every change.
module tb_decouple_reset_sequencer;

  typedef struct {
    int         at;
    logic [7:0] v;
    string      name;
  } exp_t;

  logic aclk;
  logic aresetn;
  int   cyc;
  int   base;
  int   ntot;
  int   nbad;
  exp_t sbq[$];

  decouple_reset_sequencer_if bus();

  decouple_reset_sequencer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  logic [7:0] vec;
  assign vec = {bus.decouple, bus.assert_reset, bus.busy, bus.isolated,
                bus.timeout_err, bus.state_o};

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [7:0] mk(logic d, logic a, logic b, logic i, logic e, logic [2:0] s);
    return {d, a, b, i, e, s};
  endfunction

  task automatic push(int at, logic [7:0] v, string name);
    exp_t e;
    e.at = at;
    e.v = v;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic chk(string name, logic [7:0] got, logic [7:0] want);
    ntot++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic at_neg(int n);
    while (cyc - base < n) @(negedge aclk);
  endtask

  // Pulse the selected inputs so they are sampled on relative edge n.
  task automatic pulse(int n, logic iso, logic rel, logic clr);
    at_neg(n - 1);
    bus.start_isolate = iso;
    bus.start_release = rel;
    bus.clear_err = clr;
    at_neg(n);
    bus.start_isolate = 1'b0;
    bus.start_release = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.start_isolate = 1'b0;
    bus.start_release = 1'b0;
    bus.clear_err = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_state", vec, 8'h00);
    base = cyc;
    aresetn = 1'b1;
  endtask

  logic [7:0] prev;
  int         rel_m;
  exp_t       em;

  initial prev = 8'h00;

  // Monitor: every output change must match the head of the scoreboard at the expected cycle.
  always @(negedge aclk) begin
    if (aresetn) begin
      rel_m = cyc - base;
      if (vec !== prev) begin
        ntot++;
        if (sbq.size() == 0) begin
          nbad++;
          $display("FAIL unexpected_change cycle=%0d got=%h", rel_m + 1, vec);
        end else begin
          em = sbq.pop_front();
          if (em.at != rel_m + 1 || vec !== em.v) begin
            nbad++;
            $display("FAIL %s got=%h@%0d want=%h@%0d", em.name, vec, rel_m + 1, em.v, em.at);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].at <= rel_m + 1) begin
        ntot++;
        nbad++;
        em = sbq.pop_front();
        $display("FAIL %s missed: got=%h want=%h@%0d", em.name, vec, em.v, em.at);
      end
    end
    prev = vec;
  end

  initial begin
    ntot = 0;
    nbad = 0;
    base = 0;
    aresetn = 1'b0;
    bus.app_idle = 1'b0;
    do_reset();

    // Isolate with app_idle high, then release.
    bus.app_idle = 1'b1;
    push(11, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), "iso_drain");
    push(12, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2), "iso_decouple");
    push(20, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3), "iso_reset");
    push(36, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4), "iso_done");
    pulse(10, 1'b1, 1'b0, 1'b0);
    push(51, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5), "rel_reset_low");
    push(59, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), "rel_done");
    pulse(50, 1'b0, 1'b1, 1'b0);

    // Illegal requests are dropped; simultaneous requests pick the legal one.
    pulse(65, 1'b0, 1'b1, 1'b0);
    push(71, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), "ign_drain");
    push(72, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2), "ign_decouple");
    push(80, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3), "ign_reset");
    pulse(70, 1'b1, 1'b0, 1'b0);
    pulse(85, 1'b1, 1'b0, 1'b0);
    pulse(90, 1'b1, 1'b1, 1'b0);
    push(96, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4), "ign_isolated");
    pulse(98, 1'b1, 1'b0, 1'b0);
    push(101, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5), "both_release");
    push(109, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), "both_done");
    pulse(100, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid RST_HOLD.
    push(121, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), "ar_drain");
    push(122, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2), "ar_decouple");
    push(130, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3), "ar_reset");
    pulse(120, 1'b1, 1'b0, 1'b0);
    at_neg(133);
    #2 aresetn = 1'b0;
    #1 chk("async_reset", vec, 8'h00);
    do_reset();

    // Drain timeout; clear on the set edge loses, later clear wins.
    bus.app_idle = 1'b0;
    push(11, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), "to_drain");
    push(1035, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2), "to_err_set");
    push(1041, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2), "to_err_clear");
    push(1043, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3), "to_reset");
    push(1059, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4), "to_isolated");
    pulse(10, 1'b1, 1'b0, 1'b0);
    pulse(1034, 1'b0, 1'b0, 1'b1);
    pulse(1040, 1'b0, 1'b0, 1'b1);
    push(1071, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5), "to_rel");
    push(1079, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), "to_rel_done");
    pulse(1070, 1'b0, 1'b1, 1'b0);

    // app_idle arrives on the same edge the drain counter is at zero.
    push(1101, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1), "race_drain");
    push(2125, mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2), "race_decouple_noerr");
    push(2133, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3), "race_reset");
    push(2149, mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4), "race_isolated");
    pulse(1100, 1'b1, 1'b0, 1'b0);
    at_neg(2123);
    bus.app_idle = 1'b1;
    at_neg(2160);

    ntot++;
    if (sbq.size() != 0) begin
      nbad++;
      $display("FAIL scoreboard_drain got=%0d want=0 pending", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/decouple_reset_sequencer.md
Name: decouple_reset_sequencer

Overview:
Hardware sequencer that drives the application-region `decouple` and `assert_reset` controls through a safe isolate/release order, replacing direct software writes.
- Isolate order: drain outstanding traffic (with timeout), assert decouple, let it settle, then hold reset.
- Release order: drop reset, let it settle, then drop decouple.
- Sits between the AXI-Lite control register file (source of the request pulses) and the clock decoupler / reset logic of the application region.

Parameters:
- SETTLE_CYCLES, 8, cycles decouple is held before reset asserts; also cycles reset is low before decouple drops; must be ≥1.
- RESET_CYCLES, 16, minimum cycles reset is held before `isolated` asserts; must be ≥1.
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for `app_idle` in DRAIN; must be ≥1.
- CNT_WIDTH, 16, width of the shared down-counter; must hold max(SETTLE_CYCLES, RESET_CYCLES, TIMEOUT_CYCLES)-1.

Ports:
- aclk  in  1  clock; all logic synchronous to its rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- start_isolate  in  1  single-cycle request to isolate the application region.
- start_release  in  1  single-cycle request to return the region to service.
- app_idle  in  1  high when the application region has no outstanding transactions.
- clear_err  in  1  single-cycle pulse that clears `timeout_err`.
- decouple  out  1  to the clock decoupler; registered.
- assert_reset  out  1  active-high reset to the application region; registered.
- busy  out  1  high in any state other than RUNNING and ISOLATED.
- isolated  out  1  high only in state ISOLATED.
- timeout_err  out  1  sticky flag: DRAIN ended by timeout.
- state_o  out  3  current state encoding, for status readback.

Behaviour:
- Reset: state=RUNNING, counter=0, and every output is 0 (decouple, assert_reset, busy, isolated, timeout_err, state_o).
- Reset takes effect immediately, including mid-sequence. There is no hold-over: the region leaves reset un-decoupled and un-reset.
- All outputs are registered Moore outputs, decoded from next-state so they change on the same edge as the state.
- decouple=1 in DEC_SETTLE, RST_HOLD, ISOLATED and RST_RELEASE.
- assert_reset=1 in RST_HOLD and ISOLATED.
- RUNNING:
  - start_isolate=1 → DRAIN; counter loads TIMEOUT_CYCLES-1.
  - start_release is ignored here.
- DRAIN:
  - app_idle=1 → DEC_SETTLE; counter loads SETTLE_CYCLES-1.
  - Else if counter==0 → DEC_SETTLE and timeout_err is set.
  - Else the counter decrements.
  - If app_idle=1 and counter==0 fall on the same edge, the idle path wins and timeout_err is not set.
- DEC_SETTLE: counter==0 → RST_HOLD and counter loads RESET_CYCLES-1; else decrement.
- RST_HOLD: counter==0 → ISOLATED; else decrement.
- ISOLATED:
  - start_release=1 → RST_RELEASE; counter loads SETTLE_CYCLES-1.
  - start_isolate is ignored here.
- RST_RELEASE: counter==0 → RUNNING; else decrement.
- Timing from start_isolate sampled at edge k, with app_idle held high:
  - DRAIN from k+1.
  - decouple rises at k+2.
  - assert_reset rises at k+2+SETTLE_CYCLES.
  - isolated rises at k+2+SETTLE_CYCLES+RESET_CYCLES.
- Timing from start_release sampled at edge m in ISOLATED:
  - assert_reset falls at m+1.
  - decouple falls at m+1+SETTLE_CYCLES.
- Requests are not queued. Any request arriving outside RUNNING/ISOLATED, or the wrong request type for the current state, is dropped.
- If start_isolate and start_release arrive together, only the one legal in the current state acts.
- timeout_err: set by a DRAIN timeout, cleared by clear_err. If set and clear happen on the same edge, set wins.
- Counter arithmetic is unsigned with no wrap; it is only decremented when nonzero.
- state_o encoding: RUNNING=0, DRAIN=1, DEC_SETTLE=2, RST_HOLD=3, ISOLATED=4, RST_RELEASE=5.

Decomposition:
- Shared package `decouple_seq_pkg` holds:
  - typedef enum logic [2:0] seq_state_t, with the encodings above.
  - localparam defaults for SETTLE_CYCLES, RESET_CYCLES and TIMEOUT_CYCLES.
- No sub-module: one FSM plus one shared down-counter, implemented inline.

Test Plan:
- Reset with app_idle=1, pulse start_isolate at cycle 10 (SETTLE=8, RESET=16) → decouple=1 at 12, assert_reset=1 at 20, isolated=1 at 36, busy=0 from 36.
- From ISOLATED, pulse start_release at cycle 50 → assert_reset=0 at 51, decouple=0 at 59, state_o=0, busy=0.
- app_idle=0 forever with TIMEOUT=1024, start_isolate at 10 → decouple=1 at 1035 and timeout_err=1. Then pulse clear_err → timeout_err=0 next cycle.
- Pulse start_release in RUNNING and start_isolate during RST_HOLD → no state change, outputs unaffected.
- Deassert aresetn asynchronously while in RST_HOLD → decouple, assert_reset and state_o go to 0 immediately, without waiting for aclk.
- Raise app_idle on the same edge the DRAIN counter hits 0 → DEC_SETTLE entered and timeout_err stays 0.
